// File: rtl/btn_bcd_counter.sv
// btn_bcd_counter: turns the raw up/down buttons into clean one-cycle
// pulses and keeps a 4-digit packed-BCD up/down counter for the display.
// The counter can be loaded from the switches; digits above 9 are clamped.
//
// Button path, per button:
//   raw -> 2-flop synchroniser -> debouncer (deb level) -> rising-edge pulse
//
// Debounced level in each direction
//   deb | meaning
//   0   | released; a press must be seen on DEB_CYCLES consecutive edges
//   1   | pressed;  a release must be seen on DEB_CYCLES consecutive edges
//
// Index 0 of the per-button vectors is btn_up; index 1 is btn_dn.
module btn_bcd_counter #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        load,
  input  logic [15:0] sw,
  output logic [15:0] cnt,
  output logic        up_pulse,
  output logic        dn_pulse,
  output logic        wrap
);

  localparam int DCW = $clog2(DEB_CYCLES);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEB_CYCLES - 1);

  logic [1:0]          sync1_q, sync1_d;
  logic [1:0]          sync2_q, sync2_d;
  logic [1:0]          deb_q, deb_d;
  logic [1:0]          deb_prev_q, deb_prev_d;
  logic [1:0][DCW-1:0] dc_q, dc_d;
  logic [1:0]          pulse_q, pulse_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                wrap_q, wrap_d;

  logic [15:0] ld_val;
  logic [15:0] inc_val;
  logic [15:0] dec_val;
  logic        inc_c;
  logic        dec_b;

  // Synchroniser, debouncer and edge detector for both buttons.
  // A glitch back to the current debounced level clears the run counter,
  // so only an uninterrupted run of DEB_CYCLES samples changes deb.
  always_comb begin
    sync1_d    = {btn_dn, btn_up};
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    dc_d       = dc_q;
    deb_prev_d = deb_q;
    pulse_d    = deb_q & ~deb_prev_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        dc_d[i] = '0;
      end else if (dc_q[i] == DC_LAST) begin
        deb_d[i] = ~deb_q[i];
        dc_d[i]  = '0;
      end else begin
        dc_d[i] = dc_q[i] + 1'b1;
      end
    end
  end

  // Candidate next counts: clamped load, BCD increment and BCD decrement.
  always_comb begin
    ld_val  = '0;
    inc_val = cnt_q;
    dec_val = cnt_q;
    inc_c   = 1'b1;
    dec_b   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ld_val[4*k +: 4] = (sw[4*k +: 4] > 4'd9) ? 4'd9 : sw[4*k +: 4];
      if (inc_c) begin
        if (cnt_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = cnt_q[4*k +: 4] + 4'd1;
          inc_c             = 1'b0;
        end
      end
      if (dec_b) begin
        if (cnt_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = cnt_q[4*k +: 4] - 4'd1;
          dec_b             = 1'b0;
        end
      end
    end
  end

  // Counter update: load beats pulses; opposite pulses together cancel.
  // A carry/borrow out of the top digit is the wrap event.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = ld_val;
    end else if (pulse_q[0] && pulse_q[1]) begin
      cnt_d = cnt_q;
    end else if (pulse_q[0]) begin
      cnt_d  = inc_val;
      wrap_d = inc_c;
    end else if (pulse_q[1]) begin
      cnt_d  = dec_val;
      wrap_d = dec_b;
    end
  end

  // State registers; reset also discards any partially qualified press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dc_q       <= '0;
      pulse_q    <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      dc_q       <= dc_d;
      pulse_q    <= pulse_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
    end
  end

  assign cnt      = cnt_q;
  assign up_pulse = pulse_q[0];
  assign dn_pulse = pulse_q[1];
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_btn_bcd_counter.sv
// tb_btn_bcd_counter: directed scenarios plus random button/load traffic,
// checked every cycle against a decimal-count reference model.
module tb_btn_bcd_counter;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_dn, load;
  logic [15:0] sw;
  logic [15:0] cnt;
  logic        up_pulse, dn_pulse, wrap;

  int checks = 0;
  int errors = 0;

  // reference model: decimal count, per-button pipeline and run length
  int m_cnt, m_wrap, m_pu, m_pd;
  int m_raw_hist [2][2];   // [button][age]: samples taken at last two edges
  int m_deb [2];
  int m_run [2];
  int m_rose [2];

  int n_up, n_dn, n_wrap, n_both;

  btn_bcd_counter #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .load(load),
    .sw(sw), .cnt(cnt), .up_pulse(up_pulse), .dn_pulse(dn_pulse), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_dec(input logic [15:0] s);
    int v = 0;
    logic [15:0] t = s;
    for (int k = 3; k >= 0; k--) begin
      int d = int'(t[4*k +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wrap = 0; m_pu = 0; m_pd = 0;
    for (int b = 0; b < 2; b++) begin
      m_raw_hist[b][0] = 0; m_raw_hist[b][1] = 0;
      m_deb[b] = 0; m_run[b] = 0; m_rose[b] = 0;
    end
  endtask

  // One rising edge of the model, using the inputs held across that edge.
  task automatic model_edge();
    int raw [2];
    raw[0] = int'(btn_up);
    raw[1] = int'(btn_dn);
    if (load) begin
      m_cnt = clamp_dec(sw); m_wrap = 0;
    end else if (m_pu != 0 && m_pd != 0) begin
      m_wrap = 0;
    end else if (m_pu != 0) begin
      m_wrap = (m_cnt == 9999) ? 1 : 0;
      m_cnt  = (m_cnt + 1) % 10000;
    end else if (m_pd != 0) begin
      m_wrap = (m_cnt == 0) ? 1 : 0;
      m_cnt  = (m_cnt + 9999) % 10000;
    end else begin
      m_wrap = 0;
    end
    // a press qualified at the previous edge shows as a pulse after this one
    m_pu = m_rose[0];
    m_pd = m_rose[1];
    for (int b = 0; b < 2; b++) begin
      // debouncer sees the raw value sampled two edges ago
      int seen = m_raw_hist[b][1];
      m_rose[b] = 0;
      if (seen != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_deb[b]  = 1 - m_deb[b];
          m_run[b]  = 0;
          m_rose[b] = m_deb[b];
        end
      end else begin
        m_run[b] = 0;
      end
      m_raw_hist[b][1] = m_raw_hist[b][0];
      m_raw_hist[b][0] = raw[b];
    end
  endtask

  task automatic step(input logic u, input logic d, input logic ld, input logic [15:0] s);
    btn_up = u; btn_dn = d; load = ld; sw = s;
    @(posedge clk);
    model_edge();
    #1;
    chk("cnt", cnt, to_bcd(m_cnt));
    chk("up_pulse", 16'(up_pulse), 16'(m_pu));
    chk("dn_pulse", 16'(dn_pulse), 16'(m_pd));
    chk("wrap", 16'(wrap), 16'(m_wrap));
    if (up_pulse) n_up++;
    if (dn_pulse) n_dn++;
    if (wrap) n_wrap++;
    if (up_pulse && dn_pulse) n_both++;
  endtask

  task automatic clr_counts();
    n_up = 0; n_dn = 0; n_wrap = 0; n_both = 0;
  endtask

  task automatic press(input logic u, input logic d, input int hold, input logic ld, input logic [15:0] s);
    repeat (hold) step(u, d, ld, s);
    repeat (DEB + 5) step(1'b0, 1'b0, ld, s);
  endtask

  initial begin
    int lat, cnt_at_lat, cnt_after;
    int ru, rd;
    logic cu, cd;
    btn_up = 0; btn_dn = 0; load = 0; sw = '0;
    rst = 1'b0;
    model_reset();
    clr_counts();
    repeat (2) @(posedge clk);
    #3;
    chk("reset_cnt", cnt, 16'h0000);
    chk("reset_pulses", 16'({up_pulse, dn_pulse, wrap}), 16'h0000);
    rst = 1'b1;
    repeat (3) step(0, 0, 0, 16'h0);

    // latency and hold: one pulse for a long press, released, pressed again
    lat = 0; cnt_at_lat = -1; cnt_after = -1;
    for (int k = 1; k <= 10 * DEB; k++) begin
      step(1, 0, 0, 16'h0);
      if (up_pulse && lat == 0) begin lat = k; cnt_at_lat = int'(cnt); end
      if (lat != 0 && k == lat + 1) cnt_after = int'(cnt);
    end
    chk("latency_steps", 16'(lat), 16'(DEB + 3));
    chk("lat_cnt_before", 16'(cnt_at_lat), 16'h0000);
    chk("lat_cnt_after", 16'(cnt_after), 16'h0001);
    repeat (DEB + 5) step(0, 0, 0, 16'h0);
    chk("hold_one_pulse", 16'(n_up), 16'd1);
    press(1, 0, DEB + 3, 0, 16'h0);
    chk("second_press_pulses", 16'(n_up), 16'd2);
    chk("second_press_cnt", cnt, 16'h0002);

    // short glitch on btn_dn never qualifies
    clr_counts();
    press(0, 1, DEB - 1, 0, 16'h0);
    chk("glitch_no_pulse", 16'(n_dn), 16'd0);
    chk("glitch_cnt", cnt, 16'h0002);

    // carry chain and wraps
    step(0, 0, 1, 16'h0999);
    chk("load_0999", cnt, 16'h0999);
    clr_counts();
    press(1, 0, DEB + 3, 0, 16'h0);
    chk("carry_1000", cnt, 16'h1000);
    chk("carry_no_wrap", 16'(n_wrap), 16'd0);
    step(0, 0, 1, 16'h9999);
    clr_counts();
    press(1, 0, DEB + 3, 0, 16'h0);
    chk("wrap_up_cnt", cnt, 16'h0000);
    chk("wrap_up_once", 16'(n_wrap), 16'd1);
    clr_counts();
    press(0, 1, DEB + 3, 0, 16'h0);
    chk("wrap_dn_cnt", cnt, 16'h9999);
    chk("wrap_dn_once", 16'(n_wrap), 16'd1);

    // clamp, and load winning over a coincident pulse
    step(0, 0, 1, 16'hFA5B);
    chk("clamp_FA5B", cnt, 16'h9959);
    clr_counts();
    press(1, 0, DEB + 3, 1, 16'h4321);
    step(0, 0, 0, 16'h0);
    chk("load_prio_pulse_seen", 16'(n_up), 16'd1);
    chk("load_prio_cnt", cnt, 16'h4321);

    // simultaneous presses cancel
    clr_counts();
    press(1, 1, DEB + 3, 0, 16'h0);
    chk("both_same_cycle", 16'(n_both), 16'd1);
    chk("both_cnt", cnt, 16'h4321);
    chk("both_no_wrap", 16'(n_wrap), 16'd0);

    // asynchronous reset mid-cycle with a count in place
    step(0, 0, 1, 16'h0123);
    chk("pre_reset_cnt", cnt, 16'h0123);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_cnt", cnt, 16'h0000);
    chk("async_rst_pulses", 16'({up_pulse, dn_pulse, wrap}), 16'h0000);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (4) step(0, 0, 0, 16'h0);
    chk("post_reset_hold", cnt, 16'h0000);

    // random traffic against the model
    ru = 0; rd = 0; cu = 0; cd = 0;
    for (int i = 0; i < 1500; i++) begin
      if (ru == 0) begin cu = 1'($urandom_range(0, 1)); ru = $urandom_range(1, 12); end
      if (rd == 0) begin cd = 1'($urandom_range(0, 1)); rd = $urandom_range(1, 12); end
      ru--; rd--;
      step(cu, cd, ($urandom_range(0, 39) == 0), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
